// File: rtl/pacman_map_arbiter_if.sv
// Tile-map arbiter bus: requester handshakes, RAM port and collision results.
// The slave modport is the arbiter; the master modport is the game logic
// together with the map RAM that answers mem_addr with mem_rdata.
interface pacman_map_arbiter_if #(
  parameter int ADDR_W = 11
);
  // collision sequencer trigger and sprite position
  logic              frame_stb;
  logic [8:0]        x_pac;
  logic [8:0]        y_pac;
  // render read port
  logic              ren_req;
  logic [ADDR_W-1:0] ren_addr;
  logic [1:0]        ren_rdata;
  logic              ren_rvalid;
  // tile write port
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_data;
  logic              wr_gnt;
  // single-port map RAM
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [1:0]        mem_wdata;
  logic [1:0]        mem_rdata;
  // collision results
  logic              blk_up;
  logic              blk_down;
  logic              blk_right;
  logic              blk_left;
  logic              coll_valid;
  logic              busy;

  modport slave (
    input  frame_stb, x_pac, y_pac,
    input  ren_req, ren_addr,
    output ren_rdata, ren_rvalid,
    input  wr_req, wr_addr, wr_data,
    output wr_gnt,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output blk_up, blk_down, blk_right, blk_left, coll_valid, busy
  );

  modport master (
    output frame_stb, x_pac, y_pac,
    output ren_req, ren_addr,
    input  ren_rdata, ren_rvalid,
    output wr_req, wr_addr, wr_data,
    input  wr_gnt,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  blk_up, blk_down, blk_right, blk_left, coll_valid, busy
  );
endinterface

// File: rtl/pacman_map_arbiter.sv
// pacman_map_arbiter: shares the single-port, 1-cycle-latency tile-map RAM
// between the renderer, the tile write port and a per-frame collision
// sequencer that reads the four tiles around the pacman sprite.
// Priority: render > write > sequencer, one RAM access per cycle.
// Optional starvation guard: define PACMAN_MAP_ARB_STARVE_GUARD_EN to let a
// write or lookup that has waited STARVE_LIMIT cycles pre-empt the renderer.
module pacman_map_arbiter #(
  parameter int MAP_W        = 32,
  parameter int MAP_H        = 36,
  parameter int TILE         = 8,
  parameter int ADDR_W       = 11,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pacman_map_arbiter_if.slave  bus
);

  localparam int TSH = $clog2(TILE);

  if ((1 << TSH) != TILE) begin : g_chk_tile
    $error("TILE must be a power of two");
  end
  if (STARVE_LIMIT < 1) begin : g_chk_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  // sequencer states
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_UP    = 3'd1;
  localparam logic [2:0] S_DOWN  = 3'd2;
  localparam logic [2:0] S_RIGHT = 3'd3;
  localparam logic [2:0] S_LEFT  = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  // owner of the read data arriving on mem_rdata this cycle
  localparam logic [2:0] T_NONE  = 3'd0;
  localparam logic [2:0] T_REN   = 3'd1;
  localparam logic [2:0] T_UP    = 3'd2;
  localparam logic [2:0] T_DOWN  = 3'd3;
  localparam logic [2:0] T_RIGHT = 3'd4;
  localparam logic [2:0] T_LEFT  = 3'd5;

  localparam logic [ADDR_W-1:0] MW      = ADDR_W'(MAP_W);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_TX = ADDR_W'(MAP_W - 1);
  localparam logic [ADDR_W-1:0] LAST_TY = ADDR_W'(MAP_H - 1);

  logic [2:0]        state;
  logic [2:0]        tag_q;
  logic [8:0]        xs;
  logic [8:0]        ys;
  logic              blk_up_q;
  logic              blk_down_q;
  logic              blk_right_q;
  logic              blk_left_q;
  logic              coll_valid_q;
  logic              busy_q;

  logic [8:0]        xs_m1;
  logic [8:0]        ys_m1;
  logic [ADDR_W-1:0] tx;
  logic [ADDR_W-1:0] ty;
  logic [ADDR_W-1:0] tx_m1;
  logic [ADDR_W-1:0] ty_m1;
  logic [ADDR_W-1:0] a_up;
  logic [ADDR_W-1:0] a_down;
  logic [ADDR_W-1:0] a_right;
  logic [ADDR_W-1:0] a_left;
  logic              edge_up;
  logic              edge_down;
  logic              edge_right;
  logic              edge_left;

  logic              seq_look;
  logic              seq_skip;
  logic              seq_req;
  logic [ADDR_W-1:0] seq_addr;
  logic [2:0]        seq_tag;

  logic              wr_force;
  logic              seq_force;
  logic              gnt_ren;
  logic              gnt_wr;
  logic              gnt_seq;

  // neighbour tile addresses from the frame snapshot
  assign xs_m1   = xs - 9'd1;
  assign ys_m1   = ys - 9'd1;
  assign tx      = ADDR_W'(xs >> TSH);
  assign ty      = ADDR_W'(ys >> TSH);
  assign tx_m1   = ADDR_W'(xs_m1 >> TSH);
  assign ty_m1   = ADDR_W'(ys_m1 >> TSH);
  assign a_up    = tx + ty_m1 * MW;
  assign a_down  = tx + (ty + ONE) * MW;
  assign a_right = tx + ONE + ty * MW;
  assign a_left  = tx_m1 + ty * MW;

  // map-border neighbours count as blocked and never touch the RAM
  assign edge_up    = (ys == 9'd0);
  assign edge_down  = (ty == LAST_TY);
  assign edge_right = (tx == LAST_TX);
  assign edge_left  = (xs == 9'd0);

  // lookup request for the current sequencer state
  always_comb begin
    seq_look = 1'b0;
    seq_skip = 1'b0;
    seq_addr = '0;
    seq_tag  = T_NONE;
    case (state)
      S_UP: begin
        seq_look = 1'b1;
        seq_skip = edge_up;
        seq_addr = a_up;
        seq_tag  = T_UP;
      end
      S_DOWN: begin
        seq_look = 1'b1;
        seq_skip = edge_down;
        seq_addr = a_down;
        seq_tag  = T_DOWN;
      end
      S_RIGHT: begin
        seq_look = 1'b1;
        seq_skip = edge_right;
        seq_addr = a_right;
        seq_tag  = T_RIGHT;
      end
      S_LEFT: begin
        seq_look = 1'b1;
        seq_skip = edge_left;
        seq_addr = a_left;
        seq_tag  = T_LEFT;
      end
      default: ;
    endcase
  end

  assign seq_req = seq_look & ~seq_skip;

`ifdef PACMAN_MAP_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] wr_wait;
  logic [CW-1:0] seq_wait;

  assign wr_force  = bus.wr_req & (wr_wait == LIM);
  assign seq_force = seq_req & (seq_wait == LIM);

  // denied-cycle counters, saturating at the limit and cleared on grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_wait  <= '0;
      seq_wait <= '0;
    end else begin
      if (!bus.wr_req || gnt_wr) wr_wait <= '0;
      else if (wr_wait != LIM)   wr_wait <= wr_wait + CW'(1);
      if (!seq_req || gnt_seq)   seq_wait <= '0;
      else if (seq_wait != LIM)  seq_wait <= seq_wait + CW'(1);
    end
  end
`else
  assign wr_force  = 1'b0;
  assign seq_force = 1'b0;
`endif

  // one RAM owner per cycle; starved requesters (if enabled) go first
  always_comb begin
    gnt_ren = 1'b0;
    gnt_wr  = 1'b0;
    gnt_seq = 1'b0;
    if (rst_n) begin
      if (wr_force)          gnt_wr  = 1'b1;
      else if (seq_force)    gnt_seq = 1'b1;
      else if (bus.ren_req)  gnt_ren = 1'b1;
      else if (bus.wr_req)   gnt_wr  = 1'b1;
      else if (seq_req)      gnt_seq = 1'b1;
    end
  end

  // RAM port mux
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    if (gnt_ren) begin
      bus.mem_addr = bus.ren_addr;
    end else if (gnt_wr) begin
      bus.mem_addr  = bus.wr_addr;
      bus.mem_we    = 1'b1;
      bus.mem_wdata = bus.wr_data;
    end else if (gnt_seq) begin
      bus.mem_addr = seq_addr;
    end
  end

  assign bus.wr_gnt     = gnt_wr;
  assign bus.ren_rvalid = (tag_q == T_REN);
  assign bus.ren_rdata  = bus.ren_rvalid ? bus.mem_rdata : 2'd0;

  // read tag and neighbour flags: border skips set immediately, reads land a cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q       <= T_NONE;
      blk_up_q    <= 1'b0;
      blk_down_q  <= 1'b0;
      blk_right_q <= 1'b0;
      blk_left_q  <= 1'b0;
    end else begin
      if (gnt_ren)      tag_q <= T_REN;
      else if (gnt_seq) tag_q <= seq_tag;
      else              tag_q <= T_NONE;

      if (seq_skip && seq_tag == T_UP)    blk_up_q    <= 1'b1;
      else if (tag_q == T_UP)             blk_up_q    <= |bus.mem_rdata;
      if (seq_skip && seq_tag == T_DOWN)  blk_down_q  <= 1'b1;
      else if (tag_q == T_DOWN)           blk_down_q  <= |bus.mem_rdata;
      if (seq_skip && seq_tag == T_RIGHT) blk_right_q <= 1'b1;
      else if (tag_q == T_RIGHT)          blk_right_q <= |bus.mem_rdata;
      if (seq_skip && seq_tag == T_LEFT)  blk_left_q  <= 1'b1;
      else if (tag_q == T_LEFT)           blk_left_q  <= |bus.mem_rdata;
    end
  end

  // collision sequencer; DONE also accepts frame_stb so back-to-back frames chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      xs           <= '0;
      ys           <= '0;
      coll_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.frame_stb) begin
            xs           <= bus.x_pac;
            ys           <= bus.y_pac;
            coll_valid_q <= 1'b0;
            busy_q       <= 1'b1;
            state        <= S_UP;
          end else begin
            state <= S_IDLE;
          end
        end
        S_UP:    if (seq_skip || gnt_seq) state <= S_DOWN;
        S_DOWN:  if (seq_skip || gnt_seq) state <= S_RIGHT;
        S_RIGHT: if (seq_skip || gnt_seq) state <= S_LEFT;
        S_LEFT:  if (seq_skip || gnt_seq) state <= S_WAIT;
        S_WAIT: begin
          // the LEFT read (if any) lands this cycle, so results are complete
          state        <= S_DONE;
          coll_valid_q <= 1'b1;
          busy_q       <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.blk_up     = blk_up_q;
  assign bus.blk_down   = blk_down_q;
  assign bus.blk_right  = blk_right_q;
  assign bus.blk_left   = blk_left_q;
  assign bus.coll_valid = coll_valid_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_pacman_map_arbiter.sv
// Directed bench for pacman_map_arbiter with a write-first 1-cycle map RAM model.
module tb_pacman_map_arbiter;

  logic clk;
  logic rst_n;
  logic ram_clr;
  int   checks;
  int   passes;
  int   fails;

  logic [1:0] ram [0:2047];

  pacman_map_arbiter_if #(.ADDR_W(11)) bus ();

  pacman_map_arbiter #(
    .MAP_W(32),
    .MAP_H(36),
    .TILE(8),
    .ADDR_W(11),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // write-first single-port RAM, read data one cycle after the address
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 2048; i++) ram[i] <= 2'd0;
      bus.mem_rdata <= 2'd0;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata     <= bus.mem_wdata;
    end else begin
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {8'd0, bus.ren_rvalid, bus.ren_rdata, bus.wr_gnt, bus.mem_addr, bus.mem_we,
            bus.mem_wdata, bus.blk_up, bus.blk_down, bus.blk_right, bus.blk_left,
            bus.coll_valid, bus.busy};
  endfunction

  function automatic logic [31:0] blk4();
    return {28'd0, bus.blk_up, bus.blk_down, bus.blk_right, bus.blk_left};
  endfunction

  task automatic write_tile(input string nm, input logic [10:0] a, input logic [1:0] d);
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    #1;
    chk({nm, "_gnt"}, 32'(bus.wr_gnt), 32'd1);
    chk({nm, "_we"}, 32'(bus.mem_we), 32'd1);
    chk({nm, "_addr"}, 32'(bus.mem_addr), 32'(a));
    chk({nm, "_wdata"}, 32'(bus.mem_wdata), 32'(d));
    @(negedge clk);
    bus.wr_req = 1'b0;
  endtask

  // uncontended frame: lookup addresses on cycles 1-4, coll_valid at cycle 6
  task automatic run_frame(input string nm, input logic [8:0] x, input logic [8:0] y,
                           input logic [31:0] a1, input logic [31:0] a2,
                           input logic [31:0] a3, input logic [31:0] a4,
                           input logic [31:0] prev_blk, input logic [31:0] exp_blk);
    @(negedge clk);
    bus.frame_stb = 1'b1; bus.x_pac = x; bus.y_pac = y;
    @(negedge clk);
    bus.frame_stb = 1'b0;
    #1;
    chk({nm, "_c1_addr"}, 32'(bus.mem_addr), a1);
    chk({nm, "_c1_busy"}, 32'(bus.busy), 32'd1);
    chk({nm, "_c1_coll"}, 32'(bus.coll_valid), 32'd0);
    chk({nm, "_c1_blk_old"}, blk4(), prev_blk);
    @(negedge clk); #1;
    chk({nm, "_c2_addr"}, 32'(bus.mem_addr), a2);
    chk({nm, "_c2_we"}, 32'(bus.mem_we), 32'd0);
    @(negedge clk); #1;
    chk({nm, "_c3_addr"}, 32'(bus.mem_addr), a3);
    @(negedge clk); #1;
    chk({nm, "_c4_addr"}, 32'(bus.mem_addr), a4);
    @(negedge clk); #1;
    chk({nm, "_c5_coll"}, 32'(bus.coll_valid), 32'd0);
    @(negedge clk); #1;
    chk({nm, "_c6_coll"}, 32'(bus.coll_valid), 32'd1);
    chk({nm, "_c6_busy"}, 32'(bus.busy), 32'd0);
    chk({nm, "_c6_blk"}, blk4(), exp_blk);
  endtask

  initial begin
    checks = 0; passes = 0; fails = 0;
    clk = 1'b0; rst_n = 1'b0; ram_clr = 1'b1;
    bus.frame_stb = 1'b0; bus.x_pac = '0; bus.y_pac = '0;
    bus.ren_req = 1'b0; bus.ren_addr = '0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs", outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; ram_clr = 1'b0;

    // map: tile 236 non-zero
    write_tile("wr236", 11'd236, 2'd1);
    run_frame("f96_64", 9'd96, 9'd64, 236, 300, 269, 267, 32'b0000, 32'b1000);

    // corner sprite: UP and LEFT skipped, tile 1 non-zero blocks RIGHT
    write_tile("wr1", 11'd1, 2'd3);
    run_frame("f0_0", 9'd0, 9'd0, 0, 32, 1, 0, 32'b1000, 32'b1011);

`ifdef PACMAN_MAP_ARB_STARVE_GUARD_EN
    // starvation guard: write forced through on the 5th denied cycle
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.ren_req = 1'b1; bus.ren_addr = 11'd5;
      bus.wr_req = 1'b1; bus.wr_addr = 11'd268; bus.wr_data = 2'd2;
      #1;
      chk("guard_wr_wait_gnt", 32'(bus.wr_gnt), 32'd0);
      chk("guard_wr_wait_addr", 32'(bus.mem_addr), 32'd5);
      if (i > 1) chk("guard_wr_wait_rvalid", 32'(bus.ren_rvalid), 32'd1);
    end
    @(negedge clk); #1;
    chk("guard_wr_gnt", 32'(bus.wr_gnt), 32'd1);
    chk("guard_wr_addr", 32'(bus.mem_addr), 32'd268);
    chk("guard_wr_we", 32'(bus.mem_we), 32'd1);
    @(negedge clk);
    bus.wr_req = 1'b0;
    #1;
    chk("guard_rvalid_gap", 32'(bus.ren_rvalid), 32'd0);
    chk("guard_ren_back", 32'(bus.mem_addr), 32'd5);
    @(negedge clk); #1;
    chk("guard_rvalid_after", 32'(bus.ren_rvalid), 32'd1);
`else
    // strict priority: render held 10 cycles starves the pending write
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.ren_req = 1'b1; bus.ren_addr = 11'd5;
      bus.wr_req = 1'b1; bus.wr_addr = 11'd268; bus.wr_data = 2'd2;
      #1;
      chk("ren_hold_gnt", 32'(bus.wr_gnt), 32'd0);
      chk("ren_hold_addr", 32'(bus.mem_addr), 32'd5);
      if (i > 0) chk("ren_hold_rvalid", 32'(bus.ren_rvalid), 32'd1);
    end
    @(negedge clk);
    bus.ren_req = 1'b0;
    #1;
    chk("wr_after_ren_gnt", 32'(bus.wr_gnt), 32'd1);
    chk("wr_after_ren_we", 32'(bus.mem_we), 32'd1);
    chk("wr_after_ren_addr", 32'(bus.mem_addr), 32'd268);
    chk("wr_after_ren_wdata", 32'(bus.mem_wdata), 32'd2);
`endif

    // read-after-write of tile 268
    @(negedge clk);
    bus.wr_req = 1'b0; bus.ren_req = 1'b1; bus.ren_addr = 11'd268;
    #1;
    chk("raw_addr", 32'(bus.mem_addr), 32'd268);
    chk("raw_no_gnt", 32'(bus.wr_gnt), 32'd0);
    @(negedge clk);
    bus.ren_req = 1'b0;
    #1;
    chk("raw_rvalid", 32'(bus.ren_rvalid), 32'd1);
    chk("raw_rdata", 32'(bus.ren_rdata), 32'd2);
    @(negedge clk); #1;
    chk("raw_rvalid_drop", 32'(bus.ren_rvalid), 32'd0);

    // sequencer lookup competing with a continuous render stream
    @(negedge clk);
    bus.frame_stb = 1'b1; bus.x_pac = 9'd96; bus.y_pac = 9'd64;
    bus.ren_req = 1'b1; bus.ren_addr = 11'd7;
`ifdef PACMAN_MAP_ARB_STARVE_GUARD_EN
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.frame_stb = 1'b0;
      #1;
      chk("guard_seq_wait_addr", 32'(bus.mem_addr), 32'd7);
    end
    @(negedge clk); #1;
    chk("guard_seq_forced", 32'(bus.mem_addr), 32'd236);
    @(negedge clk);
    bus.ren_req = 1'b0;
    #1;
    chk("guard_seq_rvalid_gap", 32'(bus.ren_rvalid), 32'd0);
    chk("guard_seq_down", 32'(bus.mem_addr), 32'd300);
`else
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      bus.frame_stb = 1'b0;
      #1;
      chk("seq_stall_addr", 32'(bus.mem_addr), 32'd7);
      chk("seq_stall_busy", 32'(bus.busy), 32'd1);
      chk("seq_stall_coll", 32'(bus.coll_valid), 32'd0);
    end
    @(negedge clk);
    bus.ren_req = 1'b0;
    #1;
    chk("seq_release_up", 32'(bus.mem_addr), 32'd236);
    @(negedge clk); #1;
    chk("seq_release_down", 32'(bus.mem_addr), 32'd300);
`endif
    @(negedge clk); #1;
    chk("seq_stall_right", 32'(bus.mem_addr), 32'd269);
    @(negedge clk); #1;
    chk("seq_stall_left", 32'(bus.mem_addr), 32'd267);
    @(negedge clk); #1;
    chk("seq_stall_wait_coll", 32'(bus.coll_valid), 32'd0);
    @(negedge clk); #1;
    chk("seq_stall_coll", 32'(bus.coll_valid), 32'd1);
    chk("seq_stall_blk", blk4(), 32'b1000);

    // frame_stb while busy is ignored; frame_stb during DONE chains a new frame
    @(negedge clk);
    bus.frame_stb = 1'b1; bus.x_pac = 9'd96; bus.y_pac = 9'd64;
    @(negedge clk);
    bus.frame_stb = 1'b0;
    #1;
    chk("busy_c1_addr", 32'(bus.mem_addr), 32'd236);
    @(negedge clk);
    bus.frame_stb = 1'b1; bus.x_pac = 9'd0; bus.y_pac = 9'd0;
    #1;
    chk("busy_c2_addr", 32'(bus.mem_addr), 32'd300);
    @(negedge clk);
    bus.frame_stb = 1'b0;
    #1;
    chk("busy_c3_old_snapshot", 32'(bus.mem_addr), 32'd269);
    @(negedge clk); #1;
    chk("busy_c4_addr", 32'(bus.mem_addr), 32'd267);
    @(negedge clk); #1;
    chk("busy_c5_coll", 32'(bus.coll_valid), 32'd0);
    @(negedge clk);
    bus.frame_stb = 1'b1;
    #1;
    chk("done_stb_coll", 32'(bus.coll_valid), 32'd1);
    chk("done_stb_blk", blk4(), 32'b1000);
    @(negedge clk);
    bus.frame_stb = 1'b0;
    #1;
    chk("chain_c1_coll", 32'(bus.coll_valid), 32'd0);
    chk("chain_c1_busy", 32'(bus.busy), 32'd1);
    chk("chain_c1_noaccess", 32'(bus.mem_addr), 32'd0);
    @(negedge clk); #1;
    chk("chain_c2_down", 32'(bus.mem_addr), 32'd32);
    @(negedge clk); #1;
    chk("chain_c3_right", 32'(bus.mem_addr), 32'd1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("chain_c5_coll", 32'(bus.coll_valid), 32'd0);
    @(negedge clk); #1;
    chk("chain_c6_coll", 32'(bus.coll_valid), 32'd1);
    chk("chain_c6_blk", blk4(), 32'b1011);

    // asynchronous reset in the middle of a sequence
    @(negedge clk);
    bus.frame_stb = 1'b1; bus.x_pac = 9'd96; bus.y_pac = 9'd64;
    @(negedge clk);
    bus.frame_stb = 1'b0;
    #1;
    chk("abort_c1_addr", 32'(bus.mem_addr), 32'd236);
    @(negedge clk); #1;
    chk("abort_c2_addr", 32'(bus.mem_addr), 32'd300);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("restart", 9'd96, 9'd64, 236, 300, 269, 267, 32'b0000, 32'b1000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
